// File: rtl/ofdm_tx_deframer_if.sv
// Stream bundle for the TX deframer: symbol input from the IFFT,
// over-the-air sample output towards the DUC, plus burst/status flags.
interface ofdm_tx_deframer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic             i_eob;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;
  logic             o_sof;
  logic             o_eof;
  logic             o_framing_err;

  modport master (
    output i_tdata, i_tlast, i_tvalid, i_eob, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid, o_sof, o_eof, o_framing_err
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, i_eob, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid, o_sof, o_eof, o_framing_err
  );
endinterface

// File: rtl/ofdm_tx_deframer.sv
// OFDM TX deframer: buffers IFFT symbols in a ping-pong RAM and replays
// them as gap zeros, preamble with double guard, and CP-prefixed data.
//
// state    | meaning
// S_IDLE   | waiting for the read bank to fill
// S_GAP    | emitting INITIAL_GAP zero samples at burst start
// S_PREFIX | emitting the guard / cyclic prefix from the symbol tail
// S_BODY   | emitting the full symbol, then releasing the bank
module ofdm_tx_deframer #(
  parameter int WIDTH                     = 32,
  parameter int INITIAL_GAP               = 24,
  parameter int LONG_PREAMBLE_NUM_SYMBOLS = 2,
  parameter int CYCLIC_PREFIX_LEN         = 16,
  parameter int SYMBOL_LEN                = 64
) (
  input logic              clk,
  input logic              reset,
  ofdm_tx_deframer_if.slave bus
);
  localparam int AW   = $clog2(SYMBOL_LEN);
  localparam int MAXC = (INITIAL_GAP > SYMBOL_LEN) ? INITIAL_GAP : SYMBOL_LEN;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(LONG_PREAMBLE_NUM_SYMBOLS + 2);
  localparam logic [AW-1:0] WR_LAST   = AW'(SYMBOL_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(INITIAL_GAP - 1);
  localparam logic [CW-1:0] BODY_LAST = CW'(SYMBOL_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_PREFIX, S_BODY} state_t;

  logic [WIDTH-1:0] mem_q [2*SYMBOL_LEN];

  logic          wr_bank_q;
  logic [AW-1:0] wr_cnt_q;
  logic [IW-1:0] sym_idx_q;
  logic [1:0]    full_q, full_d;
  logic [1:0]    fp_q, pre_q, eob_q;
  logic          fe_q;

  state_t        state_q;
  logic          rd_bank_q;
  logic [CW-1:0] rd_cnt_q;
  logic          rd_sob_q;
  logic          o_tvalid_q, o_tlast_q, o_sof_q, o_eof_q;
  logic [WIDTH-1:0] o_tdata_q;
  logic          o_rel_q, o_rel_bank_q;

  logic          wr_fire, wr_last, wr_is_pre;
  logic          load_en, rel, rd_nxt;
  logic [CW-1:0] cur_plen, nxt_plen;
  logic [AW:0]   rd_addr;
  logic [WIDTH-1:0] rd_data;

  function automatic logic [CW-1:0] prefix_len(input logic fp, input logic pre);
    logic [CW-1:0] p;
    if (fp)       p = CW'(2 * CYCLIC_PREFIX_LEN);
    else if (pre) p = '0;
    else          p = CW'(CYCLIC_PREFIX_LEN);
    return p;
  endfunction

  assign bus.i_tready = !full_q[wr_bank_q];
  assign wr_fire      = bus.i_tvalid && !full_q[wr_bank_q];
  assign wr_last      = (wr_cnt_q == WR_LAST);
  assign wr_is_pre    = int'(sym_idx_q) < LONG_PREAMBLE_NUM_SYMBOLS;

  // The output register reloads whenever it is empty or being consumed.
  assign load_en  = !o_tvalid_q || bus.o_tready;
  // A bank is freed only once its final body sample has left the block.
  assign rel      = o_tvalid_q && bus.o_tready && o_rel_q;
  assign rd_nxt   = ~rd_bank_q;
  assign cur_plen = prefix_len(fp_q[rd_bank_q], pre_q[rd_bank_q]);
  assign nxt_plen = prefix_len(fp_q[rd_nxt], pre_q[rd_nxt]);

  // Read address: prefix walks the symbol tail (modulo SYMBOL_LEN), body walks from 0.
  always_comb begin
    rd_addr = {rd_bank_q, rd_cnt_q[AW-1:0]};
    if (state_q == S_PREFIX) rd_addr = {rd_bank_q, rd_cnt_q[AW-1:0] - cur_plen[AW-1:0]};
  end
  assign rd_data = mem_q[rd_addr];

  // Bank-full flags: write close and read release may hit different banks together.
  always_comb begin
    full_d = full_q;
    if (wr_fire && wr_last) full_d[wr_bank_q] = 1'b1;
    if (rel)                full_d[o_rel_bank_q] = 1'b0;
  end

  // Symbol RAM write port.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[{wr_bank_q, wr_cnt_q}] <= bus.i_tdata;
  end

  // Write side: sample count, bank tagging, symbol index and framing check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      sym_idx_q <= '0;
      full_q    <= '0;
      fp_q      <= '0;
      pre_q     <= '0;
      eob_q     <= '0;
      fe_q      <= 1'b0;
    end else begin
      full_q <= full_d;
      fe_q   <= 1'b0;
      if (wr_fire) begin
        fe_q     <= bus.i_tlast ^ wr_last;
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_last) begin
          wr_bank_q        <= ~wr_bank_q;
          pre_q[wr_bank_q] <= wr_is_pre;
          fp_q[wr_bank_q]  <= wr_is_pre && (sym_idx_q == '0);
          eob_q[wr_bank_q] <= bus.i_eob && bus.i_tlast;
          if (bus.i_eob && bus.i_tlast) sym_idx_q <= '0;
          else if (wr_is_pre)           sym_idx_q <= sym_idx_q + 1'b1;
        end
      end
    end
  end

  // Read FSM with registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      rd_sob_q     <= 1'b1;
      o_tvalid_q   <= 1'b0;
      o_tdata_q    <= '0;
      o_tlast_q    <= 1'b0;
      o_sof_q      <= 1'b0;
      o_eof_q      <= 1'b0;
      o_rel_q      <= 1'b0;
      o_rel_bank_q <= 1'b0;
    end else begin
      if (load_en) begin
        o_tvalid_q <= 1'b0;
        o_tlast_q  <= 1'b0;
        o_sof_q    <= 1'b0;
        o_eof_q    <= 1'b0;
        o_rel_q    <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (full_q[rd_bank_q]) begin
            rd_cnt_q <= '0;
            if (rd_sob_q && INITIAL_GAP > 0) state_q <= S_GAP;
            else if (cur_plen == '0)         state_q <= S_BODY;
            else                             state_q <= S_PREFIX;
          end
        end
        S_GAP: begin
          if (load_en) begin
            o_tvalid_q <= 1'b1;
            o_tdata_q  <= '0;
            o_sof_q    <= rd_sob_q;
            rd_sob_q   <= 1'b0;
            if (rd_cnt_q == GAP_LAST) begin
              o_tlast_q <= 1'b1;
              rd_cnt_q  <= '0;
              state_q   <= (cur_plen == '0) ? S_BODY : S_PREFIX;
            end else begin
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
        S_PREFIX: begin
          if (load_en) begin
            o_tvalid_q <= 1'b1;
            o_tdata_q  <= rd_data;
            o_sof_q    <= rd_sob_q;
            rd_sob_q   <= 1'b0;
            if (rd_cnt_q == cur_plen - 1'b1) begin
              rd_cnt_q <= '0;
              state_q  <= S_BODY;
            end else begin
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
        S_BODY: begin
          if (load_en) begin
            o_tvalid_q <= 1'b1;
            o_tdata_q  <= rd_data;
            o_sof_q    <= rd_sob_q;
            rd_sob_q   <= 1'b0;
            if (rd_cnt_q == BODY_LAST) begin
              o_tlast_q    <= 1'b1;
              o_eof_q      <= eob_q[rd_bank_q];
              o_rel_q      <= 1'b1;
              o_rel_bank_q <= rd_bank_q;
              rd_bank_q    <= rd_nxt;
              rd_cnt_q     <= '0;
              if (eob_q[rd_bank_q]) begin
                rd_sob_q <= 1'b1;
                state_q  <= S_IDLE;
              end else if (!full_q[rd_nxt]) begin
                state_q <= S_IDLE;
              end else if (nxt_plen == '0) begin
                state_q <= S_BODY;
              end else begin
                state_q <= S_PREFIX;
              end
            end else begin
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_tdata       = o_tdata_q;
  assign bus.o_tvalid      = o_tvalid_q;
  assign bus.o_tlast       = o_tlast_q;
  assign bus.o_sof         = o_sof_q;
  assign bus.o_eof         = o_eof_q;
  assign bus.o_framing_err = fe_q;
endmodule

// File: tb/tb_ofdm_tx_deframer.sv
// Directed bench for ofdm_tx_deframer: burst sequencing, backpressure,
// back-to-back bursts, framing errors, bank release and async reset.
`timescale 1ns/1ps
module tb_ofdm_tx_deframer;
  localparam int W   = 32;
  localparam int GAP = 24;
  localparam int LP  = 2;
  localparam int CP  = 16;
  localparam int SL  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ofdm_tx_deframer_if #(.WIDTH(W)) bus ();

  ofdm_tx_deframer #(
    .WIDTH(W), .INITIAL_GAP(GAP), .LONG_PREAMBLE_NUM_SYMBOLS(LP),
    .CYCLIC_PREFIX_LEN(CP), .SYMBOL_LEN(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ready_mode = 0;
  logic [34:0] rx_q[$];
  logic [34:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] word(input int sym, input int k);
    return {16'(sym), 16'(k)};
  endfunction

  // Records each beat that will be taken at the next rising edge.
  always @(negedge clk) begin
    if (!reset && bus.o_tvalid && bus.o_tready)
      rx_q.push_back({bus.o_sof, bus.o_eof, bus.o_tlast, bus.o_tdata});
    if (!reset && bus.o_framing_err) fe_cnt++;
  end

  // Output-side ready: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    bus.o_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.o_tready = 1'b1;
        1:       bus.o_tready = 1'($urandom_range(0, 1));
        default: bus.o_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d beats seen", rx_q.size());
    $fatal(1, "watchdog");
  end

  task automatic add_burst(input int first_sym, input int nsym);
    for (int k = 0; k < GAP; k++)
      exp_q.push_back({(k == 0), 1'b0, (k == GAP - 1), 32'd0});
    for (int i = 0; i < nsym; i++) begin
      int p;
      p = (i == 0) ? 2 * CP : (i < LP) ? 0 : CP;
      for (int k = 0; k < p; k++)
        exp_q.push_back({1'b0, 1'b0, 1'b0, word(first_sym + i, SL - p + k)});
      for (int k = 0; k < SL; k++)
        exp_q.push_back({1'b0, (i == nsym - 1) && (k == SL - 1), (k == SL - 1), word(first_sym + i, k)});
    end
  endtask

  task automatic send_symbol(input int sym, input bit eob, input int err_pos, input bit rnd, input int nsamp);
    int k;
    int cyc;
    bit acc;
    k = 0;
    cyc = 0;
    while (k < nsamp && cyc < 3000) begin
      bus.i_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.i_tdata  = word(sym, k);
      bus.i_tlast  = (k == SL - 1) || (k == err_pos);
      bus.i_eob    = eob && (k == SL - 1);
      @(negedge clk);
      acc = bus.i_tvalid && bus.i_tready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    bus.i_eob    = 1'b0;
    chk($sformatf("sym%0d_len", sym), k, nsamp);
  endtask

  task automatic send_burst(input int first_sym, input int nsym, input bit rnd);
    for (int i = 0; i < nsym; i++)
      send_symbol(first_sym + i, (i == nsym - 1), -1, rnd, SL);
  endtask

  task automatic check_out(input string tag, input int nlast_exp);
    int cyc;
    int nlast;
    cyc = 0;
    nlast = 0;
    while (rx_q.size() < exp_q.size() && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (40) @(posedge clk);
    #1;
    chk({tag, "_beats"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      int e0;
      e0 = n_err;
      chk($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
      if (n_err != e0) break;
    end
    foreach (rx_q[i]) if (rx_q[i][32]) nlast++;
    chk({tag, "_tlast_cnt"}, nlast, nlast_exp);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.i_eob    = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_o_tvalid", bus.o_tvalid, 0);
    chk("rst_o_tlast", bus.o_tlast, 0);
    chk("rst_o_sof", bus.o_sof, 0);
    chk("rst_o_eof", bus.o_eof, 0);
    chk("rst_o_framing_err", bus.o_framing_err, 0);
    chk("rst_i_tready", bus.i_tready, 1);

    // 2 preamble + 3 data symbols, output always ready: 424 beats
    ready_mode = 0;
    fe_cnt = 0;
    add_burst(0, 5);
    send_burst(0, 5, 0);
    check_out("basic", 6);
    chk("basic_ferr", fe_cnt, 0);

    // same burst with random backpressure and input gaps
    ready_mode = 1;
    fe_cnt = 0;
    add_burst(20, 5);
    send_burst(20, 5, 1);
    check_out("rand", 6);
    chk("rand_ferr", fe_cnt, 0);

    // back-to-back bursts: second one restarts gap, sof and preamble tagging
    ready_mode = 0;
    add_burst(40, 5);
    add_burst(50, 5);
    send_burst(40, 5, 0);
    send_burst(50, 5, 0);
    check_out("b2b", 12);

    // early tlast at sample 10: one error pulse, symbol length unchanged
    fe_cnt = 0;
    add_burst(60, 1);
    send_symbol(60, 1, 10, 0, SL);
    check_out("early_tlast", 2);
    chk("early_tlast_pulses", fe_cnt, 1);

    // output stalled while both banks fill, then released
    ready_mode = 2;
    add_burst(70, 5);
    send_symbol(70, 0, -1, 0, SL);
    send_symbol(71, 0, -1, 0, SL);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_i_tready", bus.i_tready, 0);
    chk("stall_no_beats", rx_q.size(), 0);
    ready_mode = 0;
    cyc = 0;
    while (!bus.i_tready && cyc < 1000) begin
      @(posedge clk); #2;
      cyc++;
    end
    // first bank frees once beat 119 (last of preamble 1 body) is taken
    chk("release_beat_count", rx_q.size(), 120);
    send_symbol(72, 0, -1, 0, SL);
    send_symbol(73, 0, -1, 0, SL);
    send_symbol(74, 1, -1, 0, SL);
    check_out("stall", 6);

    // async reset in the middle of a data symbol
    ready_mode = 0;
    send_symbol(80, 0, -1, 0, SL);
    send_symbol(81, 0, -1, 0, SL);
    send_symbol(82, 0, -1, 0, 20);
    chk("pre_rst_o_tvalid", bus.o_tvalid, 1);
    #2 reset = 1'b1;
    #1 chk("async_rst_o_tvalid", bus.o_tvalid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    add_burst(90, 1);
    send_symbol(90, 1, -1, 0, SL);
    check_out("post_rst", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
